// File: rtl/gtx_loop_checker_if.sv
// RX stream bundle from the GTX wrapper into the loopback checker.
// Optional code-error flags exist only when LOOP_CHK_CODE_ERR_EN is defined.
interface gtx_loop_checker_if;
  logic        data_valid_in;
  logic [31:0] rxdata_in;
  logic [3:0]  rxcharisk_in;
`ifdef LOOP_CHK_CODE_ERR_EN
  logic [3:0]  rxdisperr_in;
  logic [3:0]  rxnotintable_in;
`endif

  // Transceiver side drives the stream.
  modport master (
    output data_valid_in,
    output rxdata_in,
`ifdef LOOP_CHK_CODE_ERR_EN
    output rxdisperr_in,
    output rxnotintable_in,
`endif
    output rxcharisk_in
  );

  // Checker side consumes the stream.
  modport slave (
    input data_valid_in,
    input rxdata_in,
`ifdef LOOP_CHK_CODE_ERR_EN
    input rxdisperr_in,
    input rxnotintable_in,
`endif
    input rxcharisk_in
  );
endinterface

// File: rtl/gtx_loop_checker.sv
// gtx_loop_checker: checks the looped-back GTX RX stream (incrementing 32-bit
// counter words interleaved with K28.5 comma words), reports lock state,
// per-word error pulses and saturating error/word counters.
// Optional build macro: LOOP_CHK_CODE_ERR_EN adds disparity / not-in-table
// checking and a code-error counter.
// Two-stage pipeline: stage 1 registers the inputs, stage 2 classifies,
// compares and registers every output.
module gtx_loop_checker #(
  parameter int LOCK_CNT  = 8,
  parameter int ERR_LIMIT = 4,
  parameter int CNT_W     = 32
) (
  input  logic              rxusrclk2_in,
  input  logic              reset_in,
  gtx_loop_checker_if.slave rx,
  input  logic              clear_counts_in,
  output logic              locked_out,
  output logic              error_pulse_out,
  output logic              lost_lock_out,
  output logic [CNT_W-1:0]  error_count_out,
`ifdef LOOP_CHK_CODE_ERR_EN
  output logic [CNT_W-1:0]  code_err_count_out,
`endif
  output logic [CNT_W-1:0]  word_count_out
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SEED   = 2'd1;  // HUNT sub-state: comma seen, waiting for a seed word
  localparam logic [1:0] ST_SYNC   = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam int GR_W = $clog2(LOCK_CNT) + 1;
  localparam int BR_W = $clog2(ERR_LIMIT) + 1;
  localparam logic [GR_W-1:0] GR_LAST = GR_W'(LOCK_CNT - 1);
  localparam logic [BR_W-1:0] BR_LAST = BR_W'(ERR_LIMIT - 1);
  localparam logic [GR_W-1:0] GR_ONE  = {{(GR_W-1){1'b0}}, 1'b1};
  localparam logic [BR_W-1:0] BR_ONE  = {{(BR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Saturating increment shared by all counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              s1_valid_d,   s1_valid_q;
  logic [31:0]       s1_data_d,    s1_data_q;
  logic [3:0]        s1_charisk_d, s1_charisk_q;
  logic [1:0]        state_d,      state_q;
  logic [31:0]       expected_d,   expected_q;
  logic [GR_W-1:0]   good_run_d,   good_run_q;
  logic [BR_W-1:0]   bad_run_d,    bad_run_q;
  logic [CNT_W-1:0]  err_cnt_d,    err_cnt_q;
  logic [CNT_W-1:0]  word_cnt_d,   word_cnt_q;
  logic              locked_d,     locked_q;
  logic              err_pulse_d,  err_pulse_q;
  logic              lost_lock_d,  lost_lock_q;
  logic              code_err_s;
  logic              is_comma_s;
  logic              is_data_s;
  logic              checked_s;
  logic              word_good_s;
`ifdef LOOP_CHK_CODE_ERR_EN
  logic              s1_cerr_d,    s1_cerr_q;
  logic [CNT_W-1:0]  cerr_cnt_d,   cerr_cnt_q;
`endif

  // Stage 1: capture the raw RX word.
  always_comb begin
    s1_valid_d   = rx.data_valid_in;
    s1_data_d    = rx.rxdata_in;
    s1_charisk_d = rx.rxcharisk_in;
`ifdef LOOP_CHK_CODE_ERR_EN
    s1_cerr_d    = (|rx.rxdisperr_in) | (|rx.rxnotintable_in);
`endif
  end

  // Stage 2: classify the word, run the HUNT/SEED/SYNC/LOCKED FSM and counters.
  always_comb begin
`ifdef LOOP_CHK_CODE_ERR_EN
    code_err_s  = s1_cerr_q;
`else
    code_err_s  = 1'b0;
`endif
    // A comma with a code error is no longer a comma; it is checked like data.
    is_comma_s  = (s1_charisk_q == 4'b0001) && (s1_data_q[7:0] == 8'hBC) && !code_err_s;
    is_data_s   = (s1_charisk_q == 4'b0000) && !code_err_s;
    checked_s   = !is_comma_s;
    word_good_s = is_data_s && (s1_data_q == expected_q);

    state_d     = state_q;
    expected_d  = expected_q;
    good_run_d  = good_run_q;
    bad_run_d   = bad_run_q;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;
    err_pulse_d = 1'b0;
    lost_lock_d = 1'b0;
`ifdef LOOP_CHK_CODE_ERR_EN
    cerr_cnt_d  = (s1_valid_q && s1_cerr_q) ? sat_inc(cerr_cnt_q) : cerr_cnt_q;
`endif

    if (!s1_valid_q) begin
      state_d     = ST_HUNT;
      good_run_d  = {GR_W{1'b0}};
      bad_run_d   = {BR_W{1'b0}};
      lost_lock_d = (state_q == ST_LOCKED);
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (is_comma_s) begin
            state_d = ST_SEED;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_SEED: begin
          if (is_data_s) begin
            expected_d = s1_data_q + 32'd1;
            good_run_d = {GR_W{1'b0}};
            state_d    = ST_SYNC;
          end else if (checked_s) begin
            state_d    = ST_HUNT;
          end else begin
            state_d    = ST_SEED;
          end
        end
        ST_SYNC: begin
          if (checked_s) begin
            expected_d = s1_data_q + 32'd1;
            if (word_good_s) begin
              if (good_run_q == GR_LAST) begin
                state_d    = ST_LOCKED;
                good_run_d = {GR_W{1'b0}};
                bad_run_d  = {BR_W{1'b0}};
              end else begin
                good_run_d = good_run_q + GR_ONE;
              end
            end else begin
              state_d     = ST_HUNT;
              good_run_d  = {GR_W{1'b0}};
              err_pulse_d = 1'b1;
            end
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_LOCKED: begin
          if (checked_s) begin
            // Re-seed from the received word so a jump costs a single error.
            expected_d = s1_data_q + 32'd1;
            word_cnt_d = sat_inc(word_cnt_q);
            if (word_good_s) begin
              bad_run_d = {BR_W{1'b0}};
            end else begin
              err_cnt_d   = sat_inc(err_cnt_q);
              err_pulse_d = 1'b1;
              if (bad_run_q == BR_LAST) begin
                state_d     = ST_HUNT;
                bad_run_d   = {BR_W{1'b0}};
                lost_lock_d = 1'b1;
              end else begin
                bad_run_d   = bad_run_q + BR_ONE;
              end
            end
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    // Clearing wins over any increment in the same cycle.
    if (clear_counts_in) begin
      err_cnt_d  = CNT_ZERO;
      word_cnt_d = CNT_ZERO;
`ifdef LOOP_CHK_CODE_ERR_EN
      cerr_cnt_d = CNT_ZERO;
`endif
    end else begin
      err_cnt_d  = err_cnt_d;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // All state: synchronous active-high reset, otherwise load the next values.
  always_ff @(posedge rxusrclk2_in) begin
    if (reset_in) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= 32'd0;
      s1_charisk_q <= 4'd0;
      state_q      <= ST_HUNT;
      expected_q   <= 32'd0;
      good_run_q   <= {GR_W{1'b0}};
      bad_run_q    <= {BR_W{1'b0}};
      err_cnt_q    <= CNT_ZERO;
      word_cnt_q   <= CNT_ZERO;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      lost_lock_q  <= 1'b0;
`ifdef LOOP_CHK_CODE_ERR_EN
      s1_cerr_q    <= 1'b0;
      cerr_cnt_q   <= CNT_ZERO;
`endif
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_charisk_q <= s1_charisk_d;
      state_q      <= state_d;
      expected_q   <= expected_d;
      good_run_q   <= good_run_d;
      bad_run_q    <= bad_run_d;
      err_cnt_q    <= err_cnt_d;
      word_cnt_q   <= word_cnt_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      lost_lock_q  <= lost_lock_d;
`ifdef LOOP_CHK_CODE_ERR_EN
      s1_cerr_q    <= s1_cerr_d;
      cerr_cnt_q   <= cerr_cnt_d;
`endif
    end
  end

  assign locked_out      = locked_q;
  assign error_pulse_out = err_pulse_q;
  assign lost_lock_out   = lost_lock_q;
  assign error_count_out = err_cnt_q;
  assign word_count_out  = word_cnt_q;
`ifdef LOOP_CHK_CODE_ERR_EN
  assign code_err_count_out = cerr_cnt_q;
`endif

endmodule
